cv_flag_unit: RTL and testbench

- Consumer end of the execute-stage ALU control interface: takes CVUpdate, the ALU/shifter flag outputs and the condition field, and owns the architectural NZCV flags.
- Evaluates ARM condition codes to produce CondExE.
- Returns PreviousCVFlag and CFlagKeptE to the ALU control decoder.
- Holds the carry kept between the two micro-ops of a split 64-bit add.

---
 rtl/cv_flag_unit_if.sv | 30 +++
 rtl/cv_flag_unit.sv | 87 ++++++++
 tb/tb_cv_flag_unit.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/cv_flag_unit_if.sv
// Execute-stage ALU control <-> flag unit bundle: decoder/ALU side drives, flag unit consumes and answers.
interface cv_flag_unit_if;
  logic       StallE;
  logic       FlushE;
  logic [3:0] CondE;
  logic       SetFlagsE;
  logic [2:0] CVUpdate;
  logic [3:0] ALUFlags;
  logic       ShifterCarryOut;
  logic       KeepCarryE;
  logic       addCarry;
  logic       RegtoCPSR;
  logic [3:0] CPSRWriteData;
  logic       CondExE;
  logic [1:0] PreviousCVFlag;
  logic       CFlagKeptE;
  logic [3:0] FlagsOut;

  modport master (
    output StallE, FlushE, CondE, SetFlagsE, CVUpdate, ALUFlags, ShifterCarryOut,
           KeepCarryE, addCarry, RegtoCPSR, CPSRWriteData,
    input  CondExE, PreviousCVFlag, CFlagKeptE, FlagsOut
  );

  modport slave (
    input  StallE, FlushE, CondE, SetFlagsE, CVUpdate, ALUFlags, ShifterCarryOut,
           KeepCarryE, addCarry, RegtoCPSR, CPSRWriteData,
    output CondExE, PreviousCVFlag, CFlagKeptE, FlagsOut
  );
endinterface

// File: rtl/cv_flag_unit.sv
// Architectural NZCV owner, condition-code evaluator and split-add carry holder for the execute stage.
// Latency: CondExE/PreviousCVFlag combinational from the registers; state updates on the next clk edge; StallE freezes all state.
module cv_flag_unit #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input logic         clk,
  input logic         reset,
  cv_flag_unit_if.slave aluCtl
);

  logic [3:0] flags;
  logic       keptCarry;
  logic       keptVld;
  logic       condEx;
  logic       upd;
  logic       nxtC;
  logic       nxtV;
  logic       unusedCvMarker;

  wire flagN = flags[3];
  wire flagZ = flags[2];
  wire flagC = flags[1];
  wire flagV = flags[0];

  always_comb begin
    condEx = 1'b1;
    case (aluCtl.CondE)
      4'b0000: condEx = flagZ;
      4'b0001: condEx = ~flagZ;
      4'b0010: condEx = flagC;
      4'b0011: condEx = ~flagC;
      4'b0100: condEx = flagN;
      4'b0101: condEx = ~flagN;
      4'b0110: condEx = flagV;
      4'b0111: condEx = ~flagV;
      4'b1000: condEx = flagC & ~flagZ;
      4'b1001: condEx = ~flagC | flagZ;
      4'b1010: condEx = (flagN == flagV);
      4'b1011: condEx = (flagN != flagV);
      4'b1100: condEx = ~flagZ & (flagN == flagV);
      4'b1101: condEx = flagZ | (flagN != flagV);
      default: condEx = 1'b1;
    endcase
  end

  assign upd = ~aluCtl.StallE & ~aluCtl.FlushE & condEx;

  // The adder carry is already ARM not-borrow, so the subtract marker plays no part in selection.
  assign nxtC = aluCtl.CVUpdate[2] ? aluCtl.ALUFlags[1] : aluCtl.ShifterCarryOut;
  assign nxtV = (aluCtl.CVUpdate[2] & ~aluCtl.CVUpdate[1]) ? aluCtl.ALUFlags[0] : flagV;
  assign unusedCvMarker = aluCtl.CVUpdate[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      flags <= RESET_FLAGS;
    end else if (upd) begin
      if (aluCtl.RegtoCPSR) begin
        flags <= aluCtl.CPSRWriteData;
      end else if (aluCtl.SetFlagsE) begin
        flags <= {aluCtl.ALUFlags[3], aluCtl.ALUFlags[2], nxtC, nxtV};
      end
    end
  end

  // A squashed first micro-op must not leave a carry behind for whatever follows.
  always_ff @(posedge clk) begin
    if (reset) begin
      keptCarry <= 1'b0;
      keptVld   <= 1'b0;
    end else if (~aluCtl.StallE & aluCtl.FlushE) begin
      keptCarry <= 1'b0;
      keptVld   <= 1'b0;
    end else if (upd & aluCtl.KeepCarryE) begin
      keptCarry <= aluCtl.ALUFlags[1];
      keptVld   <= 1'b1;
    end else if (upd & aluCtl.addCarry & keptVld) begin
      keptCarry <= 1'b0;
      keptVld   <= 1'b0;
    end
  end

  assign aluCtl.CondExE        = condEx;
  assign aluCtl.PreviousCVFlag = flags[1:0];
  assign aluCtl.CFlagKeptE     = keptCarry;
  assign aluCtl.FlagsOut       = flags;

endmodule

// File: tb/tb_cv_flag_unit.sv
// Directed-vector bench: stimulus queues expected outputs per cycle, a negedge monitor pops and compares.
module tb_cv_flag_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cv_flag_unit_if aluCtl();

  cv_flag_unit #(.RESET_FLAGS(4'b0000)) dut (
    .clk   (clk),
    .reset (reset),
    .aluCtl(aluCtl)
  );

  typedef struct {
    logic [3:0] f;
    logic       c;
    logic       k;
  } exp_t;

  exp_t  sb[$];
  string nameQ[$];
  int    checks = 0;
  int    errors = 0;

  localparam logic [3:0] EQ = 4'h0, NE = 4'h1, HI = 4'h8, GE = 4'hA, LT = 4'hB,
                         LE = 4'hD, AL = 4'hE, NV = 4'hF;

  task automatic drv(input logic [3:0] cond, input logic setF, input logic [2:0] cvu,
                     input logic [3:0] alu, input logic shc, input logic keep,
                     input logic addc, input logic r2c, input logic [3:0] wd,
                     input logic stall, input logic flush);
    aluCtl.CondE           = cond;
    aluCtl.SetFlagsE       = setF;
    aluCtl.CVUpdate        = cvu;
    aluCtl.ALUFlags        = alu;
    aluCtl.ShifterCarryOut = shc;
    aluCtl.KeepCarryE      = keep;
    aluCtl.addCarry        = addc;
    aluCtl.RegtoCPSR       = r2c;
    aluCtl.CPSRWriteData   = wd;
    aluCtl.StallE          = stall;
    aluCtl.FlushE          = flush;
  endtask

  task automatic idle(input logic [3:0] cond);
    drv(cond, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
  endtask

  task automatic expect_out(input string name, input logic [3:0] f, input logic c, input logic k);
    exp_t e;
    e.f = f;
    e.c = c;
    e.k = k;
    sb.push_back(e);
    nameQ.push_back(name);
  endtask

  task automatic nextCyc();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t  e;
      string n;
      e = sb.pop_front();
      n = nameQ.pop_front();
      checks++;
      if (aluCtl.FlagsOut !== e.f) begin
        errors++;
        $display("FAIL %s.FlagsOut got %b want %b", n, aluCtl.FlagsOut, e.f);
      end
      checks++;
      if (aluCtl.CondExE !== e.c) begin
        errors++;
        $display("FAIL %s.CondExE got %b want %b", n, aluCtl.CondExE, e.c);
      end
      checks++;
      if (aluCtl.CFlagKeptE !== e.k) begin
        errors++;
        $display("FAIL %s.CFlagKeptE got %b want %b", n, aluCtl.CFlagKeptE, e.k);
      end
      checks++;
      if (aluCtl.PreviousCVFlag !== e.f[1:0]) begin
        errors++;
        $display("FAIL %s.PreviousCVFlag got %b want %b", n, aluCtl.PreviousCVFlag, e.f[1:0]);
      end
    end
  end

  initial begin
    idle(AL);
    nextCyc();
    // Reset held across two edges; outputs reflect the reset flags.
    idle(EQ);                                                          expect_out("rst_eq", 4'b0000, 1'b0, 1'b0);
    nextCyc();
    idle(AL);                                                          expect_out("rst_al", 4'b0000, 1'b1, 1'b0);
    nextCyc();
    reset = 1'b0;
    // SUBS
    drv(AL, 1, 3'b101, 4'b0110, 0, 0, 0, 0, 4'b0000, 0, 0);            expect_out("subs", 4'b0000, 1'b1, 1'b0);
    nextCyc();
    idle(EQ);                                                          expect_out("subs_eq", 4'b0110, 1'b1, 1'b0);
    nextCyc();
    idle(HI);                                                          expect_out("subs_hi", 4'b0110, 1'b0, 1'b0);
    nextCyc();
    drv(AL, 0, 3'b000, 4'b0000, 0, 0, 0, 1, 4'b0001, 0, 0);            expect_out("msr_v1", 4'b0110, 1'b1, 1'b0);
    nextCyc();
    // ANDS: C from shifter, V held
    drv(AL, 1, 3'b000, 4'b1011, 0, 0, 0, 0, 4'b0000, 0, 0);            expect_out("ands", 4'b0001, 1'b1, 1'b0);
    nextCyc();
    drv(AL, 0, 3'b000, 4'b0000, 0, 0, 0, 1, 4'b0000, 0, 0);            expect_out("ands_res", 4'b1001, 1'b1, 1'b0);
    nextCyc();
    // ADDS KeepV
    drv(AL, 1, 3'b110, 4'b0011, 0, 0, 0, 0, 4'b0000, 0, 0);            expect_out("adds_kv", 4'b0000, 1'b1, 1'b0);
    nextCyc();
    drv(AL, 0, 3'b000, 4'b0000, 0, 0, 0, 1, 4'b0100, 0, 0);            expect_out("adds_kv_res", 4'b0010, 1'b1, 1'b0);
    nextCyc();
    drv(NE, 1, 3'b110, 4'b0011, 0, 0, 0, 0, 4'b0000, 0, 0);            expect_out("adds_ne", 4'b0100, 1'b0, 1'b0);
    nextCyc();
    idle(LT);                                                          expect_out("ne_held_lt", 4'b0100, 1'b0, 1'b0);
    nextCyc();
    // Split add capture then consume
    drv(AL, 0, 3'b000, 4'b0010, 0, 1, 0, 0, 4'b0000, 0, 0);            expect_out("keep", 4'b0100, 1'b1, 1'b0);
    nextCyc();
    drv(AL, 0, 3'b000, 4'b0000, 0, 0, 1, 0, 4'b0000, 0, 0);            expect_out("consume", 4'b0100, 1'b1, 1'b1);
    nextCyc();
    idle(AL);                                                          expect_out("consumed", 4'b0100, 1'b1, 1'b0);
    nextCyc();
    drv(AL, 0, 3'b000, 4'b0010, 0, 1, 0, 0, 4'b0000, 0, 1);            expect_out("keep_flush", 4'b0100, 1'b1, 1'b0);
    nextCyc();
    idle(AL);                                                          expect_out("keep_flushed", 4'b0100, 1'b1, 1'b0);
    nextCyc();
    drv(AL, 0, 3'b000, 4'b0010, 0, 1, 0, 0, 4'b0000, 0, 0);            expect_out("keep2", 4'b0100, 1'b1, 1'b0);
    nextCyc();
    // Flush clears a live kept carry and blocks a flag update
    drv(AL, 1, 3'b101, 4'b1111, 0, 0, 0, 0, 4'b0000, 0, 1);            expect_out("flush_live", 4'b0100, 1'b1, 1'b1);
    nextCyc();
    idle(AL);                                                          expect_out("flush_after", 4'b0100, 1'b1, 1'b0);
    nextCyc();
    drv(AL, 1, 3'b101, 4'b1111, 0, 0, 0, 0, 4'b0000, 1, 0);            expect_out("stall", 4'b0100, 1'b1, 1'b0);
    nextCyc();
    drv(AL, 1, 3'b101, 4'b1111, 0, 0, 0, 1, 4'b1010, 0, 0);            expect_out("msr", 4'b0100, 1'b1, 1'b0);
    nextCyc();
    idle(GE);                                                          expect_out("msr_ge", 4'b1010, 1'b0, 1'b0);
    nextCyc();
    idle(LE);                                                          expect_out("msr_le", 4'b1010, 1'b1, 1'b0);
    nextCyc();
    idle(NV);                                                          expect_out("cond_nv", 4'b1010, 1'b1, 1'b0);
    nextCyc();
    // Reset in the middle of a split add drops the kept carry
    drv(AL, 0, 3'b000, 4'b0010, 0, 1, 0, 0, 4'b0000, 0, 0);            expect_out("keep3", 4'b1010, 1'b1, 1'b0);
    nextCyc();
    reset = 1'b1;
    idle(AL);                                                          expect_out("mid_rst", 4'b1010, 1'b1, 1'b1);
    nextCyc();
    reset = 1'b0;
    idle(AL);                                                          expect_out("post_rst", 4'b0000, 1'b1, 1'b0);
    nextCyc();
    nextCyc();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
